// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module : if_stage
// Brief  : MIPS instruction-fetch stage. Owns the PC and issues one fetch at a
//          time. Holds the IF/ID register, with a skid slot for stalls.
// Rev    : 1.0  initial release
// ============================================================================
module if_stage #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = {PC_WIDTH{1'b0}}
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                redirect,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ready,
    input  logic                imem_rvalid,
    input  logic [31:0]         imem_rdata,
    output logic                if_id_valid,
    output logic [31:0]         if_id_instr,
    output logic [5:0]          if_id_op,
    output logic [PC_WIDTH-1:0] if_id_pc4
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } stateT;

    localparam logic [PC_WIDTH-1:0] c_pcInc     = PC_WIDTH'(4);
    localparam logic [PC_WIDTH-1:0] c_alignMask = ~(PC_WIDTH'(3));

    stateT               r_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] r_reqPc;
    logic                r_discard;
    logic                r_imemReq;
    logic [31:0]         r_skidInstr;
    logic [PC_WIDTH-1:0] r_skidPc4;
    logic                r_ifIdValid;
    logic [31:0]         r_ifIdInstr;
    logic [PC_WIDTH-1:0] r_ifIdPc4;

    logic                w_accept;
    logic                w_ifIdFree;
    logic [PC_WIDTH-1:0] w_redirTarget;
    logic [PC_WIDTH-1:0] w_reqPc4;

    // r_imemReq is only ever set while in S_REQ, so it doubles as the REQ qualifier
    assign w_accept      = (r_state == S_REQ) && r_imemReq && imem_ready;
    assign w_ifIdFree    = !r_ifIdValid || !stall;
    assign w_redirTarget = redirect_pc & c_alignMask;
    assign w_reqPc4      = r_reqPc + c_pcInc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_REQ;
            r_pc        <= RESET_PC;
            r_reqPc     <= RESET_PC;
            r_discard   <= 1'b0;
            r_imemReq   <= 1'b0;
            r_skidInstr <= 32'd0;
            r_skidPc4   <= {PC_WIDTH{1'b0}};
            r_ifIdValid <= 1'b0;
            r_ifIdInstr <= 32'd0;
            r_ifIdPc4   <= {PC_WIDTH{1'b0}};
        end else begin
            // Unstalled ID consumes the current word; a load below overrides the bubble
            if (!stall) begin
                r_ifIdValid <= 1'b0;
            end

            if (redirect) begin
                r_pc        <= w_redirTarget;
                r_ifIdValid <= 1'b0;
                case (r_state)
                    S_REQ: begin
                        if (w_accept) begin
                            r_discard <= 1'b1;
                            r_state   <= S_WAIT;
                            r_imemReq <= 1'b0;
                        end else begin
                            r_imemReq <= 1'b1;
                        end
                    end
                    S_WAIT: begin
                        if (imem_rvalid) begin
                            r_discard <= 1'b0;
                            r_state   <= S_REQ;
                            r_imemReq <= 1'b1;
                        end else begin
                            r_discard <= 1'b1;
                        end
                    end
                    default: begin
                        r_state   <= S_REQ;
                        r_imemReq <= 1'b1;
                    end
                endcase
            end else begin
                case (r_state)
                    S_REQ: begin
                        if (w_accept) begin
                            r_reqPc   <= r_pc;
                            r_pc      <= r_pc + c_pcInc;
                            r_state   <= S_WAIT;
                            r_imemReq <= 1'b0;
                        end else begin
                            r_imemReq <= 1'b1;
                        end
                    end
                    S_WAIT: begin
                        if (imem_rvalid) begin
                            if (r_discard) begin
                                r_discard <= 1'b0;
                                r_state   <= S_REQ;
                                r_imemReq <= 1'b1;
                            end else if (w_ifIdFree) begin
                                r_ifIdValid <= 1'b1;
                                r_ifIdInstr <= imem_rdata;
                                r_ifIdPc4   <= w_reqPc4;
                                r_state     <= S_REQ;
                                r_imemReq   <= 1'b1;
                            end else begin
                                r_skidInstr <= imem_rdata;
                                r_skidPc4   <= w_reqPc4;
                                r_state     <= S_HOLD;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (!stall) begin
                            r_ifIdValid <= 1'b1;
                            r_ifIdInstr <= r_skidInstr;
                            r_ifIdPc4   <= r_skidPc4;
                            r_state     <= S_REQ;
                            r_imemReq   <= 1'b1;
                        end
                    end
                    default: begin
                        r_state   <= S_REQ;
                        r_imemReq <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign imem_req    = r_imemReq;
    assign imem_addr   = r_pc;
    assign if_id_valid = r_ifIdValid;
    assign if_id_instr = r_ifIdInstr;
    assign if_id_op    = r_ifIdInstr[31:26];
    assign if_id_pc4   = r_ifIdPc4;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_if_stage
// Brief  : Scoreboard bench for if_stage: directed scenarios then random traffic.
// Rev    : 1.0  initial release
// ============================================================================
module tb_if_stage;

    localparam int          PC_WIDTH = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [5:0]  if_id_op;
    logic [31:0] if_id_pc4;

    always #5 clk = ~clk;

    if_stage #(.PC_WIDTH(PC_WIDTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_op(if_id_op),
        .if_id_pc4(if_id_pc4)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } expT;

    // Reference model: program-order stream of fetched words still owed to ID
    expT         expQ[$];
    logic [31:0] expAddrQ[$];
    logic [31:0] expPc = RESET_PC;
    logic [31:0] imemInit [logic [31:0]];
    int          memDue[$];
    logic [31:0] memAddr[$];
    int          memLat = 1;
    int          cycleNo = 0;
    int          nCompared = 0;
    int          nMismatch = 0;
    int          nConsumed = 0;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (imemInit.exists(a)) return imemInit[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cycleNo);
        end
    endtask

    // Called just after a falling edge: drives one cycle of inputs and updates the model
    task automatic driveCycle(input logic st, input logic rd, input logic [31:0] rpc, input logic rdy);
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        imem_ready  = rdy;
        if (!rst_n) begin
            expQ.delete();
            expAddrQ.delete();
            expPc = RESET_PC;
        end
        if (memDue.size() > 0 && memDue[0] <= cycleNo) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memWord(memAddr[0]);
            void'(memDue.pop_front());
            void'(memAddr.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        if (rst_n && imem_req && rdy) begin
            expAddrQ.push_back(expPc);
            memDue.push_back(cycleNo + memLat);
            memAddr.push_back(imem_addr);
            if (!rd) begin
                expQ.push_back('{instr: memWord(expPc), pc4: expPc + 32'd4});
                expPc = expPc + 32'd4;
            end
        end
        if (rd) begin
            expQ.delete();
            expPc = rpc & ~32'h3;
        end
        cycleNo++;
    endtask

    // Monitor: samples just before each rising edge and pops the scoreboard
    initial begin
        logic        outstanding;
        expT         e;
        logic [31:0] a;
        outstanding = 1'b0;
        forever begin
            @(negedge clk);
            #4;
            if (!rst_n) begin
                outstanding = 1'b0;
            end else begin
                if (imem_rvalid) outstanding = 1'b0;
                if (imem_req && imem_ready) begin
                    check("single_outstanding", 32'(outstanding), 32'd0);
                    if (expAddrQ.size() == 0) begin
                        nCompared++;
                        nMismatch++;
                        $display("FAIL fetch_addr: got request 0x%08h, expected none", imem_addr);
                    end else begin
                        a = expAddrQ.pop_front();
                        check("fetch_addr", imem_addr, a);
                    end
                    outstanding = 1'b1;
                end
                if (if_id_valid && !stall && !redirect) begin
                    nConsumed++;
                    if (expQ.size() == 0) begin
                        nCompared++;
                        nMismatch++;
                        $display("FAIL ifid_spurious: got instr 0x%08h, expected none", if_id_instr);
                    end else begin
                        e = expQ.pop_front();
                        check("ifid_instr", if_id_instr, e.instr);
                        check("ifid_pc4", if_id_pc4, e.pc4);
                        check("ifid_op", 32'(if_id_op), 32'(e.instr[31:26]));
                    end
                end
            end
        end
    end

    initial begin
        logic        st;
        logic        rd;
        logic        rdy;
        logic [31:0] rpc;
        imemInit[32'h0] = 32'h8C0A_0004;
        imemInit[32'h4] = 32'h8C0A_0004;
        imemInit[32'h8] = 32'hAC0B_0008;

        // Reset held
        @(negedge clk);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(if_id_valid), 32'd0);
        check("rst_instr", if_id_instr, 32'd0);
        check("rst_pc4", if_id_pc4, 32'd0);
        check("rst_addr", imem_addr, RESET_PC);
        driveCycle(0, 0, 32'd0, 1);
        @(negedge clk); rst_n = 1'b1; driveCycle(0, 0, 32'd0, 1);
        @(negedge clk);
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, 32'h0);
        driveCycle(0, 0, 32'd0, 1);
        @(negedge clk); check("lat_valid_early", 32'(if_id_valid), 32'd0); driveCycle(0, 0, 32'd0, 1);
        @(negedge clk);
        check("lat_valid", 32'(if_id_valid), 32'd1);
        check("lat_op", 32'(if_id_op), 32'd35);
        check("lat_pc4", if_id_pc4, 32'd4);
        driveCycle(0, 0, 32'd0, 1);
        @(negedge clk); driveCycle(0, 0, 32'd0, 1);
        @(negedge clk); check("addr8", imem_addr, 32'h8); driveCycle(1, 0, 32'd0, 1);
        @(negedge clk); driveCycle(1, 0, 32'd0, 1);
        // Stalled with fetch of 8 parked in the skid slot
        @(negedge clk);
        check("hold_req", 32'(imem_req), 32'd0);
        check("hold_valid", 32'(if_id_valid), 32'd1);
        check("hold_instr", if_id_instr, 32'h8C0A_0004);
        check("hold_pc4", if_id_pc4, 32'd8);
        driveCycle(1, 0, 32'd0, 1);
        @(negedge clk); driveCycle(1, 0, 32'd0, 1);
        @(negedge clk); check("hold_instr2", if_id_instr, 32'h8C0A_0004); driveCycle(0, 0, 32'd0, 1);
        @(negedge clk);
        check("skid_instr", if_id_instr, 32'hAC0B_0008);
        check("skid_op", 32'(if_id_op), 32'd43);
        check("skid_pc4", if_id_pc4, 32'd12);
        memLat = 3;
        driveCycle(1, 0, 32'd0, 1);
        // Redirect while waiting, under stall
        @(negedge clk); memLat = 1; check("pre_redir_valid", 32'(if_id_valid), 32'd1); driveCycle(1, 1, 32'h43, 1);
        @(negedge clk);
        check("redir_valid", 32'(if_id_valid), 32'd0);
        check("redir_wait_req", 32'(imem_req), 32'd0);
        driveCycle(0, 0, 32'd0, 1);
        @(negedge clk); driveCycle(0, 0, 32'd0, 1);
        @(negedge clk);
        check("redir_addr", imem_addr, 32'h40);
        check("redir_drop_valid", 32'(if_id_valid), 32'd0);
        driveCycle(0, 1, 32'h100, 1);
        // Redirect coincident with accept: that response must be discarded
        @(negedge clk); check("redir_acc_req", 32'(imem_req), 32'd0); driveCycle(0, 0, 32'd0, 1);
        @(negedge clk);
        check("redir_acc_addr", imem_addr, 32'h100);
        check("redir_acc_valid", 32'(if_id_valid), 32'd0);
        driveCycle(1, 0, 32'd0, 1);
        @(negedge clk); driveCycle(1, 0, 32'd0, 1);
        @(negedge clk); check("load_pc4", if_id_pc4, 32'h104); driveCycle(1, 0, 32'd0, 1);
        @(negedge clk); driveCycle(1, 0, 32'd0, 1);
        @(negedge clk);
        check("skidfull_req", 32'(imem_req), 32'd0);
        check("skidfull_valid", 32'(if_id_valid), 32'd1);
        driveCycle(1, 1, 32'h200, 1);
        @(negedge clk);
        check("hold_redir_valid", 32'(if_id_valid), 32'd0);
        check("hold_redir_req", 32'(imem_req), 32'd1);
        memLat = 3;
        driveCycle(0, 0, 32'd0, 1);
        // Reset pulse while waiting; the late response must be ignored
        @(negedge clk); check("pre_rst_req", 32'(imem_req), 32'd0); rst_n = 1'b0; driveCycle(0, 0, 32'd0, 0);
        @(negedge clk);
        check("midrst_instr", if_id_instr, 32'd0);
        check("midrst_pc4", if_id_pc4, 32'd0);
        rst_n = 1'b1;
        memLat = 1;
        driveCycle(0, 0, 32'd0, 0);
        @(negedge clk); check("late_pre_valid", 32'(if_id_valid), 32'd0); driveCycle(0, 0, 32'd0, 0);
        @(negedge clk);
        check("late_valid", 32'(if_id_valid), 32'd0);
        check("late_addr", imem_addr, RESET_PC);
        check("late_req", 32'(imem_req), 32'd1);
        driveCycle(0, 0, 32'd0, 1);

        // Random traffic, with redirect targets biased toward the PC wrap point
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            memLat = $urandom_range(1, 4);
            st     = ($urandom_range(0, 9) < 3);
            rd     = ($urandom_range(0, 19) == 0);
            rdy    = ($urandom_range(0, 9) < 7);
            rpc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
            driveCycle(st, rd, rpc, rdy);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            driveCycle(0, 0, 32'd0, 1);
        end
        @(negedge clk);
        check("liveness", 32'(nConsumed >= 100), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
`default_nettype wire
